// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small byte FIFO.
// Each rising edge of start enqueues data_i. Queued bytes leave back-to-back
// as 8N1 frames (or 8 data + parity), LSB first, CLKS_PER_BIT clocks per bit.
// tx, busy and tx_done are registered copies of the next-state line values.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data_i,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic          PAR_EN   = (PARITY_EN != 0);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Edge detector
  logic start_prev;
  logic push;
  logic push_ok;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    head;
  logic          pop;

  // Transmit FSM
  logic [2:0]    state,   state_n;
  logic [TW-1:0] timer,   timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift,   shift_n;
  logic          par_bit, par_n;
  logic          last_tick;
  logic          line_n;

  assign push       = start & ~start_prev;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok    = push & (~fifo_full | pop);
  assign head       = mem[rd_ptr];
  assign last_tick  = (timer == BIT_LAST);

  // Remember last cycle's start level for rising-edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rstn) start_prev <= 1'b0;
    else       start_prev <= start;
  end

  // Storage write; the contents need no reset because count gates every read.
  // NOTE: memories are deliberately left out of reset so they map onto plain
  // RAM/register-file cells instead of a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push & fifo_full & ~pop) overflow <= 1'b1;
    end
  end

  // Next-state logic for the frame sequencer, including the pop decision.
  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    par_n     = par_bit;
    pop       = 1'b0;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = (^head) ^ PAR_ODD;
          timer_n = '0;
          state_n = S_START;
        end
      end

      S_START: begin
        if (last_tick) begin
          timer_n   = '0;
          bit_idx_n = 3'd0;
          state_n   = S_DATA;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      S_DATA: begin
        if (last_tick) begin
          timer_n = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = PAR_EN ? S_PARITY : S_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      S_PARITY: begin
        if (last_tick) begin
          timer_n = '0;
          state_n = S_STOP;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      S_STOP: begin
        if (last_tick) begin
          timer_n = '0;
          // Chain straight into the next START so queued frames stay contiguous.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = head;
            par_n   = (^head) ^ PAR_ODD;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      default: begin
        timer_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Line level implied by the next state, so the registered tx lines up with it.
  always_comb begin
    case (state_n)
      S_START:  line_n = 1'b0;
      S_DATA:   line_n = shift_n[0];
      S_PARITY: line_n = par_n;
      default:  line_n = 1'b1;
    endcase
  end

  // Sequencer registers and the registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      par_bit <= par_n;
      tx      <= line_n;
      busy    <= (state_n != S_IDLE);
      tx_done <= (state_n == S_STOP) && (timer_n == BIT_LAST);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four instances (depth 8, depth 4, even parity, odd parity)
// share one stimulus stream. A frame-level reference model (byte queue plus a
// position-in-frame counter) predicts every output of every instance each cycle;
// directed scenarios add spot checks against hand-derived constants.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int NI  = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [7:0]    data_i;
  logic [NI-1:0] tx_w, busy_w, done_w, empty_w, full_w, ovf_w;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .PARITY_EN(0), .PARITY_ODD(0)) u_base (
    .clk(clk), .rstn(rstn), .data_i(data_i), .start(start), .tx(tx_w[0]), .busy(busy_w[0]),
    .tx_done(done_w[0]), .fifo_empty(empty_w[0]), .fifo_full(full_w[0]), .overflow(ovf_w[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) u_d4 (
    .clk(clk), .rstn(rstn), .data_i(data_i), .start(start), .tx(tx_w[1]), .busy(busy_w[1]),
    .tx_done(done_w[1]), .fifo_empty(empty_w[1]), .fifo_full(full_w[1]), .overflow(ovf_w[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(0)) u_pev (
    .clk(clk), .rstn(rstn), .data_i(data_i), .start(start), .tx(tx_w[2]), .busy(busy_w[2]),
    .tx_done(done_w[2]), .fifo_empty(empty_w[2]), .fifo_full(full_w[2]), .overflow(ovf_w[2]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(1)) u_pod (
    .clk(clk), .rstn(rstn), .data_i(data_i), .start(start), .tx(tx_w[3]), .busy(busy_w[3]),
    .tx_done(done_w[3]), .fifo_empty(empty_w[3]), .fifo_full(full_w[3]), .overflow(ovf_w[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-instance configuration
  function automatic int  dep(int i);  return (i == 1) ? 4 : 8;     endfunction
  function automatic bit  pen(int i);  return (i >= 2);             endfunction
  function automatic bit  podd(int i); return (i == 3);             endfunction
  function automatic int  flen(int i); return (pen(i) ? 11 : 10) * CPB; endfunction

  // Reference model: queue of bytes and the position within the current frame.
  logic [7:0] mq   [NI][8];
  int         mcnt [NI];
  bit         mact [NI];
  int         mpos [NI];
  logic [7:0] mcur [NI];
  bit         movf [NI];
  bit         mprev;

  task automatic model_step();
    bit push;
    bit pop;
    int pre;
    if (!rstn) begin
      mprev = 1'b0;
      for (int i = 0; i < NI; i++) begin
        mcnt[i] = 0; mact[i] = 1'b0; mpos[i] = 0; movf[i] = 1'b0;
      end
    end else begin
      push  = start && !mprev;
      mprev = start;
      for (int i = 0; i < NI; i++) begin
        pre = mcnt[i];
        pop = 1'b0;
        if (mact[i]) begin
          mpos[i]++;
          if (mpos[i] == flen(i)) mact[i] = 1'b0;
        end
        if (!mact[i] && pre > 0) begin
          mcur[i] = mq[i][0];
          for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
          mcnt[i]--;
          mact[i] = 1'b1;
          mpos[i] = 0;
          pop     = 1'b1;
        end
        if (push) begin
          if (pre < dep(i) || pop) begin
            mq[i][mcnt[i]] = data_i;
            mcnt[i]++;
          end else begin
            movf[i] = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  function automatic logic exp_line(int i);
    int k = mpos[i] / CPB;
    if (!mact[i])          return 1'b1;
    if (k == 0)            return 1'b0;
    if (k <= 8)            return mcur[i][k-1];
    if (k == 9 && pen(i))  return (^mcur[i]) ^ podd(i);
    return 1'b1;
  endfunction

  // {tx, busy, tx_done, fifo_empty, fifo_full, overflow}
  function automatic logic [5:0] exp_out(int i);
    return {exp_line(i), mact[i], mact[i] && (mpos[i] == flen(i) - 1),
            mcnt[i] == 0, mcnt[i] == dep(i), movf[i]};
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < NI; i++)
        check($sformatf("model_inst%0d", i),
              32'({tx_w[i], busy_w[i], done_w[i], empty_w[i], full_w[i], ovf_w[i]}),
              32'(exp_out(i)));
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    data_i = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_all_idle();
    int t = 0;
    while (!((&empty_w) && !(|busy_w)) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", 32'(t < 2000), 32'd1);
  endtask

  task automatic wait_fall(input int i, output int t);
    t = 0;
    while (tx_w[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int         n, p, t, f, nd, gap, dones, lows, hold;
    logic [9:0] bits;

    rstn = 1'b0; start = 1'b0; data_i = 8'h00;
    repeat (3) @(negedge clk);
    model_on = 1'b1;
    for (int i = 0; i < NI; i++)
      check($sformatf("reset_out_inst%0d", i),
            32'({tx_w[i], busy_w[i], done_w[i], empty_w[i], full_w[i], ovf_w[i]}), 32'b100100);
    rstn = 1'b1;

    // Single byte 0xA5: latency, line pattern, tx_done position, busy afterwards.
    @(negedge clk); data_i = 8'hA5; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (tx_w[0] && n < 20) begin @(negedge clk); n++; end
    check("a5_fall_edges", 32'(n), 32'd2);
    bits[0] = tx_w[0];
    for (int k = 1; k < 10; k++) begin
      repeat (CPB) @(negedge clk);
      bits[k] = tx_w[0];
    end
    check("a5_line", 32'(bits), 32'b1101001010);
    p = 9 * CPB;
    while (!done_w[0] && p < 100) begin @(negedge clk); p++; end
    check("a5_done_pos", 32'(p), 32'd39);
    @(negedge clk);
    check("a5_busy_after", 32'(busy_w[0]), 32'd0);

    // start held high for 100 cycles while data_i wanders: one frame only.
    wait_all_idle();
    dones = 0;
    @(negedge clk); data_i = 8'h3C; start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      dones += int'(done_w[0]);
      data_i = 8'($urandom);
    end
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      dones += int'(done_w[0]);
    end
    check("hold_frames", 32'(dones), 32'd1);
    check("hold_empty", 32'(empty_w[0]), 32'd1);

    // Burst of three: contiguous frames, 120 clocks first fall to last tx_done.
    wait_all_idle();
    fork
      begin
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
      end
      begin
        t = 0;
        while (tx_w[0] && t < 20) begin @(negedge clk); t++; end
        f = cyc; nd = 0; gap = 0;
        while (nd < 3 && t < 500) begin
          @(negedge clk);
          t++;
          if (done_w[0])  nd++;
          if (!busy_w[0]) gap++;
        end
        check("burst_frames", 32'(nd), 32'd3);
        check("burst_span", 32'(cyc - f), 32'd119);
        check("burst_gap", 32'(gap), 32'd0);
      end
    join

    // Depth 4: six pushes during the first frame -> full, one drop, five frames.
    wait_all_idle();
    for (int q = 0; q < 6; q++) begin
      push_byte(8'h40 + 8'(q));
      if (q == 4) begin
        check("d4_full_after5", 32'(full_w[1]), 32'd1);
        check("d4_no_ovf_yet", 32'(ovf_w[1]), 32'd0);
      end
    end
    check("d4_ovf", 32'(ovf_w[1]), 32'd1);
    dones = 0; t = 0;
    while (!(empty_w[1] && !busy_w[1]) && t < 1000) begin
      @(negedge clk);
      t++;
      dones += int'(done_w[1]);
    end
    check("d4_frames", 32'(dones), 32'd5);
    check("d4_ovf_sticky", 32'(ovf_w[1]), 32'd1);

    // Parity on 0x07 (three ones): even -> 1, odd -> 0, 44-clock frame.
    wait_all_idle();
    push_byte(8'h07);
    wait_fall(2, t);
    repeat (9 * CPB) @(negedge clk);
    check("par_even_bit", 32'(tx_w[2]), 32'd1);
    check("par_odd_bit", 32'(tx_w[3]), 32'd0);
    p = 9 * CPB;
    while (!done_w[2] && p < 100) begin @(negedge clk); p++; end
    check("par_done_pos", 32'(p), 32'd43);

    // Reset during DATA bit 3 of 0xFF with two bytes queued.
    wait_all_idle();
    push_byte(8'hFF);
    wait_fall(0, t);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (4 * CPB - 3) @(negedge clk);
    check("pre_reset_queued", 32'(empty_w[0]), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("reset_mid_inst%0d", i),
            32'({tx_w[i], empty_w[i], ovf_w[i]}), 32'b110);
    rstn = 1'b1;
    lows = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      lows += int'(!tx_w[0]);
    end
    check("post_reset_quiet", 32'(lows), 32'd0);

    // start high across reset release enqueues exactly one byte.
    data_i = 8'h5A; start = 1'b1; rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("start_across_reset", 32'(empty_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_all_idle();

    // Random traffic: bursts, long holds, occasional reset, model-checked.
    for (int it = 0; it < 250; it++) begin
      gap = int'($urandom_range(0, 40));
      repeat (gap) begin
        @(negedge clk);
        data_i = 8'($urandom);
      end
      @(negedge clk);
      data_i = 8'($urandom);
      start  = 1'b1;
      hold   = int'($urandom_range(1, 4));
      repeat (hold) @(negedge clk);
      start = 1'b0;
      if ($urandom_range(0, 49) == 0) begin
        start = 1'($urandom);
        rstn  = 1'b0;
        @(negedge clk);
        rstn  = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_all_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
